dma_channel_arbiter: RTL and testbench
======================================

Name: dma_channel_arbiter

Overview:
Round-robin arbiter that shares the single DMA read channel (startDMA/addrDMA/fromMemDMA/rdyDMA) between up to four peripheral requesters, such as the buzzer, graphics, disk controller and coprocessor.
- Latches one-cycle request pulses and issues them one at a time to the DMA block.
- Returns each 16-bit read word to its owner with a one-cycle ready pulse.
- Aborts a transfer that gets no DMA response within a cycle budget.

Parameters:
NREQ, 4, number of requesters (2..4; ports sized for 4, unused inputs tied 0)
TIMEOUT, 1024, max WAIT cycles before abort (>=2)
TW, 11, timeout counter width (must hold TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
req_start  in  4  per-requester start pulse, one cycle
req_addr  in  64  requester i address in bits [16i+15:16i], sampled with req_start[i]
req_rdy  out  4  one-cycle completion pulse to requester i
req_err  out  4  one-cycle abort pulse to requester i, coincident with req_rdy[i]
req_data  out  16  returned word, shared; valid while req_rdy pulses, held until the next completion
startDMA  out  1  one-cycle start to the DMA channel
addrDMA  out  16  address to the DMA channel, held from ISSUE until the next grant
fromMemDMA  in  16  DMA read data, valid with rdyDMA
rdyDMA  in  1  DMA completion strobe
busy  out  1  1 in ISSUE or WAIT
grant_id  out  2  index of the current or last granted requester

Behaviour:
- Reset (rst=0, async): all outputs 0; pending[3:0]=0; stored addresses=0; state=IDLE; last=NREQ-1, so requester 0 wins the first arbitration; timeout counter=0.
- Request capture: at a clock edge where req_start[i]=1 and pending[i]=0, set pending[i] and store addr[i].
  - req_start[i] while pending[i]=1 is ignored; the original address is kept.
  - A start on the same edge that completes requester i's transfer is accepted, giving a new pending request with the new address.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any pending bit is set, grant the first set index searching last+1, last+2, ... modulo NREQ. Load addrDMA and grant_id, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle): startDMA=1. Clear the timeout counter. Go to WAIT.
  - WAIT: rdyDMA is sampled only here.
    - rdyDMA=1: req_data<=fromMemDMA; req_rdy[g] pulses next cycle; pending[g] cleared; last<=g; go to IDLE.
    - Otherwise increment the counter. At TIMEOUT-1 with no rdyDMA: req_data<=16'hFFFF; req_rdy[g] and req_err[g] pulse; pending[g] cleared; last<=g; go to IDLE.
    - A late rdyDMA arriving after abort (in IDLE or ISSUE) is ignored.
- Latency, uncontended: req_start sampled at edge k. pending is visible in cycle k+1; grant at edge k+1; startDMA high in cycle k+2; WAIT from cycle k+3. req_rdy is high during the cycle after the edge that samples rdyDMA.
- Minimum spacing between back-to-back grants is 3 cycles: IDLE, ISSUE, WAIT.
- Fairness: a continuously requesting port waits at most NREQ-1 other transfers.
- Simultaneous req_start on several ports: all are captured on the same edge and served in round-robin order.
- rdyDMA and the timeout on the same cycle: rdyDMA wins and req_err stays 0.
- Reset asserted mid-WAIT: the transfer is dropped and no req_rdy is issued. Requesters must re-issue after reset.
- Index arithmetic is modulo NREQ. Indices >= NREQ are never granted, even if their req_start is 1.

Test Plan:
- Single request: req_start[2]=1, addr 0x1234 at edge k; DMA returns rdyDMA with 0xBEEF 5 cycles after startDMA. Required: startDMA and addrDMA=0x1234 in cycle k+2, grant_id=2, req_rdy=4'b0100 for 1 cycle, req_data=0xBEEF, req_err=0.
- Simultaneous start on all 4 ports after reset, addrs 0x10/0x20/0x30/0x40. Required: startDMA order 0x10, 0x20, 0x30, 0x40; req_rdy pulses in order 0,1,2,3; busy drops only after the 4th completion.
- Fairness: port 0 re-requests immediately after each completion while port 3 holds a request. Required: grant order 0,3,0,...; port 3 is served before port 0's second transfer.
- Timeout with TIMEOUT=8: request on port 1, rdyDMA never asserted. Required: req_rdy[1] and req_err[1] pulse together with req_data=0xFFFF; a rdyDMA pulse 2 cycles later causes no req_rdy.
- Duplicate start: req_start[0] with addr 0x100, then req_start[0] with 0x200 while still pending. Required: exactly one transfer, with addrDMA=0x100.
- Reset mid-WAIT: rst=0 for 1 cycle during WAIT. Required: all outputs 0 asynchronously, no req_rdy; a fresh request on port 3 afterwards loses to a simultaneous port-0 request (last reset to 3).

Source files
------------

// File: rtl/dma_channel_arbiter.sv
// ---------------------------------------------------------------------------
// dma_channel_arbiter
//
// Shares the single DMA read channel between up to four peripheral
// requesters (buzzer, graphics, disk controller, coprocessor). One-cycle
// request pulses are latched into a pending set and granted one at a time
// in round-robin order. Each returned word is handed back to its owner
// with a one-cycle ready pulse. A transfer that gets no DMA response
// within TIMEOUT cycles is aborted with an error pulse and data 16'hFFFF.
//
// Parameters
//   NREQ     number of active requesters (2..4). Ports are always sized
//            for 4; starts on indices >= NREQ are never captured.
//   TIMEOUT  maximum WAIT cycles before abort (>= 2)
//   TW       timeout counter width (must hold TIMEOUT)
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   req_start   per-requester start pulse
//   req_addr    requester i address in [16i+15:16i], sampled with start
//   req_rdy     one-cycle completion pulse per requester
//   req_err     one-cycle abort pulse, coincident with req_rdy
//   req_data    returned word, held until the next completion
//   startDMA    one-cycle start to the DMA channel
//   addrDMA     DMA address, held from ISSUE until the next grant
//   fromMemDMA  DMA read data, valid with rdyDMA
//   rdyDMA      DMA completion strobe (only honoured in WAIT)
//   busy        high in ISSUE or WAIT
//   grant_id    current or last granted requester
// ---------------------------------------------------------------------------
module dma_channel_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_start,
  input  logic [63:0] req_addr,
  output logic [3:0]  req_rdy,
  output logic [3:0]  req_err,
  output logic [15:0] req_data,
  output logic        startDMA,
  output logic [15:0] addrDMA,
  input  logic [15:0] fromMemDMA,
  input  logic        rdyDMA,
  output logic        busy,
  output logic [1:0]  grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] VALID_MASK = 4'((1 << NREQ) - 1);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [3:0]    r_pending;
  logic [15:0]   r_addr [4];
  logic [1:0]    r_last;
  logic [1:0]    r_grant;
  logic [TW-1:0] r_cnt;
  logic [15:0]   r_addr_dma;
  logic [15:0]   r_data;
  logic [3:0]    r_rdy;
  logic [3:0]    r_err;

  logic          w_any;
  logic [1:0]    w_pick;
  logic [1:0]    w_idx;
  logic          w_done;
  logic          w_abort;
  logic [3:0]    w_clear;
  logic [3:0]    w_take;
  logic [3:0]    w_pending_nxt;

  // Round-robin pick: scan last+NREQ down to last+1 so that the final hit
  // (closest to last+1) is the one that sticks.
  always_comb begin
    w_any  = |r_pending;
    w_pick = '0;
    w_idx  = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      w_idx = 2'((32'(r_last) + k) % NREQ);
      if (r_pending[w_idx]) begin
        w_pick = w_idx;
      end
    end
  end

  // Completion/abort of the granted transfer; rdyDMA wins over the timeout.
  always_comb begin
    w_done  = (r_state == S_WAIT) && rdyDMA;
    w_abort = (r_state == S_WAIT) && !rdyDMA && (r_cnt == TW'(TIMEOUT - 1));
    w_clear = (w_done || w_abort) ? (4'b0001 << r_grant) : 4'b0000;
  end

  // A start is taken when the slot is free, or is being freed on this very
  // edge by its own completion.
  always_comb begin
    w_take        = req_start & VALID_MASK & (~r_pending | w_clear);
    w_pending_nxt = (r_pending & ~w_clear) | w_take;
  end

  // Next-state and FSM outputs.
  always_comb begin
    w_state_nxt = r_state;
    startDMA    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        startDMA    = 1'b1;
        busy        = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (w_done || w_abort) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_addr[i] <= '0;
      end
      r_last     <= 2'(NREQ - 1);
      r_grant    <= '0;
      r_cnt      <= '0;
      r_addr_dma <= '0;
      r_data     <= '0;
      r_rdy      <= '0;
      r_err      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_take[i]) begin
          r_addr[i] <= req_addr[16*i +: 16];
        end
      end
      r_rdy <= '0;
      r_err <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant    <= w_pick;
            r_addr_dma <= r_addr[w_pick];
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (w_done) begin
            r_data <= fromMemDMA;
            r_rdy  <= w_clear;
            r_last <= r_grant;
          end else if (w_abort) begin
            r_data <= 16'hFFFF;
            r_rdy  <= w_clear;
            r_err  <= w_clear;
            r_last <= r_grant;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_rdy  = r_rdy;
  assign req_err  = r_err;
  assign req_data = r_data;
  assign addrDMA  = r_addr_dma;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
module tb_dma_channel_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_start = '0;
  logic [63:0] req_addr = '0;
  logic [3:0]  req_rdy;
  logic [3:0]  req_err;
  logic [15:0] req_data;
  logic        startDMA;
  logic [15:0] addrDMA;
  logic [15:0] fromMemDMA;
  logic        rdyDMA;
  logic        busy;
  logic [1:0]  grant_id;

  // DMA responder and manual late-pulse drivers are OR-ed together.
  logic        rsp_rdy = 1'b0;
  logic [15:0] rsp_data = '0;
  logic        man_rdy = 1'b0;
  logic [15:0] man_data = '0;
  assign rdyDMA     = rsp_rdy | man_rdy;
  assign fromMemDMA = rsp_data | man_data;

  int          dly = 5;
  bit          mute = 1'b0;
  bit          fixed = 1'b0;
  logic [15:0] fixed_data = '0;
  logic [15:0] rsp_d;

  int total = 0;
  int bad   = 0;

  typedef struct {logic [1:0] gid; logic [15:0] addr;} st_t;
  typedef struct {logic [3:0] rdy; logic [3:0] err; logic [15:0] data;} cp_t;
  st_t sq[$];
  cp_t cq[$];
  st_t ms;
  cp_t mc;

  always #5 clk = ~clk;

  dma_channel_arbiter #(.NREQ(4), .TIMEOUT(8), .TW(4)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_addr(req_addr),
    .req_rdy(req_rdy), .req_err(req_err), .req_data(req_data),
    .startDMA(startDMA), .addrDMA(addrDMA), .fromMemDMA(fromMemDMA),
    .rdyDMA(rdyDMA), .busy(busy), .grant_id(grant_id)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  function automatic void push_st(input logic [1:0] g, input logic [15:0] a);
    st_t s;
    s.gid = g; s.addr = a;
    sq.push_back(s);
  endfunction

  function automatic void push_cp(input logic [3:0] r, input logic [3:0] e, input logic [15:0] d);
    cp_t c;
    c.rdy = r; c.err = e; c.data = d;
    cq.push_back(c);
  endfunction

  // DMA responder: answers each startDMA after dly cycles unless muted.
  // Default data is the inverted address.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && startDMA && !mute) begin
        rsp_d = fixed ? fixed_data : ~addrDMA;
        repeat (dly) @(posedge clk);
        #1 rsp_rdy = 1'b1; rsp_data = rsp_d;
        @(posedge clk);
        #1 rsp_rdy = 1'b0; rsp_data = '0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a start or a
  // completion.
  always @(negedge clk) begin
    if (rst) begin
      if (startDMA) begin
        chk("busy_in_issue", 32'(busy), 32'd1);
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start: got addr=%h gid=%0d required none", addrDMA, grant_id);
        end else begin
          ms = sq.pop_front();
          chk("start_addr", 32'(addrDMA), 32'(ms.addr));
          chk("start_gid", 32'(grant_id), 32'(ms.gid));
        end
      end
      if ((req_rdy != 4'b0) || (req_err != 4'b0)) begin
        if (cq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got rdy=%b err=%b data=%h required none", req_rdy, req_err, req_data);
        end else begin
          mc = cq.pop_front();
          chk("done_rdy", 32'(req_rdy), 32'(mc.rdy));
          chk("done_err", 32'(req_err), 32'(mc.err));
          chk("done_data", 32'(req_data), 32'(mc.data));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0; req_start = '0; req_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic issue(input logic [3:0] st, input logic [63:0] ad);
    @(posedge clk);
    #1 req_start = st; req_addr = ad;
    @(posedge clk);
    #1 req_start = '0; req_addr = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((sq.size() != 0 || cq.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_drain: got %0d starts/%0d completions outstanding required 0", name, sq.size(), cq.size());
      sq.delete();
      cq.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!startDMA && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL %s_start: got no startDMA required one within 40 cycles", name);
    end
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200us");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_rdy", 32'(req_rdy), 32'd0);
    chk("rst_err", 32'(req_err), 32'd0);
    chk("rst_data", 32'(req_data), 32'd0);
    chk("rst_start", 32'(startDMA), 32'd0);
    chk("rst_addr", 32'(addrDMA), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);

    // Single request on port 2, fixed return data, 5-cycle DMA latency
    fixed = 1'b1; fixed_data = 16'hBEEF;
    push_st(2'd2, 16'h1234);
    push_cp(4'b0100, 4'b0000, 16'hBEEF);
    issue(4'b0100, 64'h0000_1234_0000_0000);
    @(negedge clk);
    chk("single_k1_start", 32'(startDMA), 32'd0);
    chk("single_k1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("single_k2_start", 32'(startDMA), 32'd1);
    n = 0;
    while (req_rdy == 4'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("single_rdy_latency", 32'(n), 32'd6);
    @(negedge clk);
    chk("single_rdy_pulse", 32'(req_rdy), 32'd0);
    chk("single_data_hold", 32'(req_data), 32'hBEEF);
    wait_idle("single", 60);
    fixed = 1'b0;

    // Simultaneous start on all ports
    do_reset();
    push_st(2'd0, 16'h0010); push_st(2'd1, 16'h0020);
    push_st(2'd2, 16'h0030); push_st(2'd3, 16'h0040);
    push_cp(4'b0001, 4'b0, 16'hFFEF); push_cp(4'b0010, 4'b0, 16'hFFDF);
    push_cp(4'b0100, 4'b0, 16'hFFCF); push_cp(4'b1000, 4'b0, 16'hFFBF);
    issue(4'b1111, 64'h0040_0030_0020_0010);
    wait_idle("simul", 120);
    chk("simul_busy_end", 32'(busy), 32'd0);
    chk("simul_data_hold", 32'(req_data), 32'hFFBF);

    // Fairness: port 0 re-requests on its completion edge while port 3 waits
    do_reset();
    push_st(2'd0, 16'h0A00); push_cp(4'b0001, 4'b0, 16'hF5FF);
    push_st(2'd3, 16'h0B00); push_cp(4'b1000, 4'b0, 16'hF4FF);
    push_st(2'd0, 16'h0A01); push_cp(4'b0001, 4'b0, 16'hF5FE);
    issue(4'b0001, 64'h0000_0000_0000_0A00);
    issue(4'b1000, 64'h0B00_0000_0000_0000);
    n = 0;
    @(negedge clk);
    while (!(rdyDMA && busy && grant_id == 2'd0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL fair_rdy: got no port-0 completion required one within 40 cycles");
    end
    req_start = 4'b0001; req_addr = 64'h0000_0000_0000_0A01;
    @(posedge clk);
    #1 req_start = '0; req_addr = '0;
    wait_idle("fair", 120);

    // Timeout: port 1, no DMA response, then a stray late rdyDMA
    mute = 1'b1;
    push_st(2'd1, 16'h0222);
    push_cp(4'b0010, 4'b0010, 16'hFFFF);
    issue(4'b0010, 64'h0000_0000_0222_0000);
    wait_start("tmo");
    n = 0;
    while (req_rdy == 4'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", 32'(n), 32'd9);
    repeat (2) @(posedge clk);
    #1 man_rdy = 1'b1; man_data = 16'h5555;
    @(posedge clk);
    #1 man_rdy = 1'b0; man_data = '0;
    wait_idle("tmo", 60);
    chk("tmo_data_hold", 32'(req_data), 32'hFFFF);
    mute = 1'b0;

    // rdyDMA on the last allowed WAIT cycle wins over the timeout
    dly = 8;
    push_st(2'd2, 16'h0333); push_cp(4'b0100, 4'b0, 16'hFCCC);
    issue(4'b0100, 64'h0000_0333_0000_0000);
    wait_idle("edge8", 60);
    // Fastest possible DMA response
    dly = 1;
    push_st(2'd3, 16'h0444); push_cp(4'b1000, 4'b0, 16'hFBBB);
    issue(4'b1000, 64'h0444_0000_0000_0000);
    wait_idle("edge1", 60);
    dly = 5;

    // Duplicate start while pending keeps the first address
    push_st(2'd0, 16'h0100); push_cp(4'b0001, 4'b0, 16'hFEFF);
    issue(4'b0001, 64'h0000_0000_0000_0100);
    issue(4'b0001, 64'h0000_0000_0000_0200);
    wait_idle("dup", 60);

    // Reset mid-WAIT drops the transfer; last returns to 3
    mute = 1'b1;
    push_st(2'd1, 16'h0555);
    issue(4'b0010, 64'h0000_0000_0555_0000);
    wait_start("rstw");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_start", 32'(startDMA), 32'd0);
    chk("rstw_addr", 32'(addrDMA), 32'd0);
    chk("rstw_gid", 32'(grant_id), 32'd0);
    chk("rstw_rdy", 32'(req_rdy), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    mute = 1'b0;
    repeat (3) @(negedge clk);
    push_st(2'd0, 16'h0A0A); push_st(2'd3, 16'h0B0B);
    push_cp(4'b0001, 4'b0, 16'hF5F5); push_cp(4'b1000, 4'b0, 16'hF4F4);
    issue(4'b1001, 64'h0B0B_0000_0000_0A0A);
    wait_idle("rstw", 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
